// File: rtl/soc_button_reader.sv
// Button reader: 2-FF sync, per-button debounce, press events/counters, femtorv read bus.
// Define SOC_BTN_IRQ_EN to add the registered pending-event interrupt output irq.
module soc_button_reader #(
  parameter int N_BTN     = 2,
  parameter int DB_CYCLES = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             mem_rstrb,
  input  logic [1:0]       mem_addr,
  output logic [31:0]      mem_rdata,
  output logic             mem_rvalid
`ifdef SOC_BTN_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [31:0]      ID_WORD = 32'h42544E00 | 32'(N_BTN);

  logic [N_BTN-1:0] sync1, sync2;
  logic [N_BTN-1:0] stable, stable_nxt;
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] events, events_nxt;
  logic [CNT_W-1:0] db_cnt     [N_BTN];
  logic [CNT_W-1:0] db_cnt_nxt [N_BTN];
  logic [7:0]       count      [N_BTN];
  logic [31:0]      rd_mux;
  logic             rd_clear;

  // Pins idle high (released), so the synchroniser resets to 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    stable_nxt = stable;
    press      = '0;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_nxt[i] = '0;
      if (sync2[i] != stable[i]) begin
        if (db_cnt[i] == DB_LAST) begin
          stable_nxt[i] = sync2[i];
          press[i]      = ~sync2[i];
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Reading EVENTS clears every bit it returned; a simultaneous press survives.
  assign rd_clear   = mem_rstrb && (mem_addr == 2'd1);
  assign events_nxt = rd_clear ? press : (events | press);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable <= '1;
      events <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      stable <= stable_nxt;
      events <= events_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt[i] <= db_cnt_nxt[i];
        if (press[i]) count[i] <= count[i] + 8'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (mem_addr)
      2'd0: rd_mux[N_BTN-1:0] = ~stable;
      2'd1: rd_mux[N_BTN-1:0] = events;
      2'd2: for (int i = 0; i < N_BTN; i++) rd_mux[8*i +: 8] = count[i];
      default: rd_mux = ID_WORD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_rdata  <= '0;
      mem_rvalid <= 1'b0;
    end else begin
      mem_rvalid <= mem_rstrb;
      if (mem_rstrb) mem_rdata <= rd_mux;
    end
  end

`ifdef SOC_BTN_IRQ_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= |events_nxt;
  end
`endif

endmodule

// File: tb/tb_soc_button_reader.sv
// Self-checking bench for soc_button_reader (N_BTN=2, DB_CYCLES=8) with a window-based
// reference model of the debounce, press events, counters and read bus.
module tb_soc_button_reader;
  localparam int N_BTN = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  btn_raw = 2'b11;
  logic        mem_rstrb = 1'b0;
  logic [1:0]  mem_addr = 2'd0;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
`ifdef SOC_BTN_IRQ_EN
  logic        irq;
`endif

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  soc_button_reader #(.N_BTN(2), .DB_CYCLES(8), .CNT_W(16)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_raw    (btn_raw),
    .mem_rstrb  (mem_rstrb),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
`ifdef SOC_BTN_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // Reference model: a level is accepted once the last 8 synchronised samples
  // (raw samples two clocks old) all disagree with the accepted level.
  logic [1:0]  rhist[$];
  logic [1:0]  m_stable;
  logic [1:0]  m_events;
  logic [7:0]  m_cnt[2];
  logic [31:0] exp_rdata;
  logic        m_all;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rhist = '{2'b11, 2'b11};
      m_stable = 2'b11;
      m_events = 2'b00;
      m_cnt[0] = 8'd0;
      m_cnt[1] = 8'd0;
      exp_rdata = 32'd0;
    end else begin
      if (mem_rstrb) begin
        case (mem_addr)
          2'd0: exp_rdata = {30'd0, ~m_stable};
          2'd1: begin exp_rdata = {30'd0, m_events}; m_events = 2'b00; end
          2'd2: exp_rdata = {16'd0, m_cnt[1], m_cnt[0]};
          default: exp_rdata = 32'h42544E00 + N_BTN;
        endcase
      end
      rhist.push_back(btn_raw);
      if (rhist.size() > 12) void'(rhist.pop_front());
      if (rhist.size() >= 10) begin
        for (int b = 0; b < 2; b++) begin
          m_all = 1'b1;
          for (int j = 2; j <= 9; j++)
            if (rhist[rhist.size()-1-j][b] == m_stable[b]) m_all = 1'b0;
          if (m_all) begin
            m_stable[b] = ~m_stable[b];
            if (!m_stable[b]) begin
              m_events[b] = 1'b1;
              m_cnt[b] = m_cnt[b] + 8'd1;
            end
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input int lo, input int hi);
    @(negedge clk);
    btn_raw[b] = 1'b0;
    repeat (lo) @(negedge clk);
    btn_raw[b] = 1'b1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d, output logic v,
                         output logic [31:0] e);
    @(negedge clk);
    mem_rstrb = 1'b1;
    mem_addr = a;
    @(posedge clk);
    #1;
    d = mem_rdata;
    v = mem_rvalid;
    e = exp_rdata;
    mem_rstrb = 1'b0;
    mem_addr = 2'($urandom);
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    logic v;
    btn_raw = 2'b11;
    resetn = 1'b0;
    #23;
    resetn = 1'b1;
    cyc(2);
    do_read(2'd0, d, v, e);
    ntotal++; if (d !== 32'd0) $display("FAIL reset_state: got %h exp %h", d, 32'd0); else npass++;
    ntotal++; if (v !== 1'b1) $display("FAIL reset_state_rvalid: got %b exp 1", v); else npass++;
    do_read(2'd3, d, v, e);
    ntotal++; if (d !== 32'h42544E02) $display("FAIL id: got %h exp %h", d, 32'h42544E02); else npass++;
    ntotal++; if (v !== 1'b1) $display("FAIL id_rvalid: got %b exp 1", v); else npass++;
    @(posedge clk); #1;
    ntotal++; if (mem_rvalid !== 1'b0) $display("FAIL rvalid_pulse: got %b exp 0", mem_rvalid); else npass++;
    ntotal++; if (mem_rdata !== 32'h42544E02) $display("FAIL rdata_hold: got %h exp %h", mem_rdata, 32'h42544E02); else npass++;
  endtask

  task automatic test_press();
    logic [31:0] d, e;
    logic v;
    @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (9) @(posedge clk);
    do_read(2'd0, d, v, e);
    ntotal++; if (d !== 32'd0) $display("FAIL state_at_9: got %h exp %h", d, 32'd0); else npass++;
    do_read(2'd0, d, v, e);
    ntotal++; if (d !== 32'd1 || v !== 1'b1) $display("FAIL state_at_10: got %h/%b exp 00000001/1", d, v); else npass++;
    do_read(2'd1, d, v, e);
    ntotal++; if (d !== 32'd1) $display("FAIL events_after_press: got %h exp %h", d, 32'd1); else npass++;
    do_read(2'd2, d, v, e);
    ntotal++; if (d !== 32'd1 || d !== e) $display("FAIL count_after_press: got %h exp %h", d, 32'd1); else npass++;
  endtask

  task automatic test_glitch();
    logic [31:0] d, e;
    logic v;
    press(1, 5, 15);
    do_read(2'd0, d, v, e);
    ntotal++; if (d !== 32'd1 || d !== e) $display("FAIL glitch_state: got %h exp %h", d, 32'd1); else npass++;
    do_read(2'd1, d, v, e);
    ntotal++; if (d !== 32'd0 || d !== e) $display("FAIL glitch_events: got %h exp %h", d, 32'd0); else npass++;
    do_read(2'd2, d, v, e);
    ntotal++; if (d !== 32'd1 || d !== e) $display("FAIL glitch_count: got %h exp %h", d, 32'd1); else npass++;
  endtask

  task automatic test_read_clear();
    logic [31:0] d, e;
    logic v;
    btn_raw[0] = 1'b1;
    cyc(12);
    @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`ifdef SOC_BTN_IRQ_EN
    ntotal++; if (irq !== 1'b1) $display("FAIL irq_rise: got %b exp 1", irq); else npass++;
`endif
    cyc(2);
    do_read(2'd1, d, v, e);
    ntotal++; if (d !== 32'd1) $display("FAIL events_first: got %h exp %h", d, 32'd1); else npass++;
`ifdef SOC_BTN_IRQ_EN
    ntotal++; if (irq !== 1'b0) $display("FAIL irq_clear: got %b exp 0", irq); else npass++;
`endif
    do_read(2'd1, d, v, e);
    ntotal++; if (d !== 32'd0) $display("FAIL events_cleared: got %h exp %h", d, 32'd0); else npass++;
    btn_raw[0] = 1'b1;
    cyc(12);
    press(0, 12, 12);
    @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (9) @(posedge clk);
    do_read(2'd1, d, v, e);
    ntotal++; if (d !== 32'd1) $display("FAIL events_clear_cycle: got %h exp %h", d, 32'd1); else npass++;
    do_read(2'd1, d, v, e);
    ntotal++; if (d !== 32'd1) $display("FAIL press_wins_clear: got %h exp %h", d, 32'd1); else npass++;
    do_read(2'd1, d, v, e);
    ntotal++; if (d !== 32'd0) $display("FAIL events_final_clear: got %h exp %h", d, 32'd0); else npass++;
    do_read(2'd2, d, v, e);
    ntotal++; if (d !== e) $display("FAIL count_read_clear: got %h exp %h", d, e); else npass++;
  endtask

  task automatic test_wrap();
    logic [31:0] d, e;
    logic v;
    int n1;
    btn_raw = 2'b11;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n1 = $urandom_range(1, 3);
    for (int k = 0; k < n1; k++) press(1, $urandom_range(8, 12), $urandom_range(8, 12));
    for (int k = 0; k < 256; k++) press(0, $urandom_range(8, 12), $urandom_range(8, 12));
    cyc(12);
    do_read(2'd2, d, v, e);
    ntotal++; if (d !== {16'd0, 8'(n1), 8'd0}) $display("FAIL count_wrap: got %h exp %h", d, {16'd0, 8'(n1), 8'd0}); else npass++;
    do_read(2'd1, d, v, e);
    ntotal++; if (d !== 32'd3) $display("FAIL events_wrap: got %h exp %h", d, 32'd3); else npass++;
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    logic v;
    for (int s = 0; s < 60; s++) begin
      btn_raw = 2'($urandom);
      for (int c = 0; c < int'($urandom_range(1, 14)); c++) begin
        if ($urandom_range(0, 3) == 0) begin
          do_read(2'($urandom), d, v, e);
          ntotal++; if (d !== e || v !== 1'b1) $display("FAIL random_read: got %h/%b exp %h/1", d, v, e); else npass++;
`ifdef SOC_BTN_IRQ_EN
          ntotal++; if (irq !== |m_events) $display("FAIL random_irq: got %b exp %b", irq, |m_events); else npass++;
`endif
        end else begin
          cyc(1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    logic v;
    btn_raw = 2'b11;
    cyc(15);
    do_read(2'd3, d, v, e);
    @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    mem_rstrb = 1'b1;
    mem_addr = 2'd3;
    resetn = 1'b0;
    #1;
    ntotal++; if (mem_rdata !== 32'd0 || mem_rvalid !== 1'b0) $display("FAIL reset_async: got %h/%b exp 0/0", mem_rdata, mem_rvalid); else npass++;
    btn_raw = 2'b11;
    @(posedge clk); #1;
    ntotal++; if (mem_rdata !== 32'd0 || mem_rvalid !== 1'b0) $display("FAIL reset_held: got %h/%b exp 0/0", mem_rdata, mem_rvalid); else npass++;
`ifdef SOC_BTN_IRQ_EN
    ntotal++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b exp 0", irq); else npass++;
`endif
    mem_rstrb = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    cyc(12);
    do_read(2'd0, d, v, e);
    ntotal++; if (d !== 32'd0 || d !== e) $display("FAIL state_after_reset: got %h exp %h", d, 32'd0); else npass++;
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_read_clear();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
